// File: rtl/othello_pkg.sv
// Shared encodings for the Othello board engines: cell values, direction
// type, flip-scan FSM states and the off-board coordinate test.
package othello_pkg;

   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] BLACK = 2'b01;
   localparam logic [1:0] WHITE = 2'b10;

   typedef logic [2:0] dir_t;

   typedef enum logic [2:0] {
      IDLE,
      SELF_RD,
      SELF_EV,
      DIR_ISSUE,
      DIR_EV,
      FLIP_SELF,
      FLIP_WALK,
      DONE
   } state_t;

   // x-borrow at x=0 turns x into F, so bit 3 also flags that case
   function automatic logic offboard(input logic [7:0] coord);
      return coord[3] | coord[7];
   endfunction

endpackage

// File: rtl/othello_flip_scan_nextcood.sv
// Single-step coordinate generator: adds the 8-bit offset of direction dir
// to a {y,x} coordinate; carries/borrows are left for the off-board test.
module nextcood
   import othello_pkg::*;
(
   input  logic [7:0] cood,
   input  dir_t       dir,
   output logic [7:0] next
);

   logic [7:0] step;

   always_comb begin
      step = 8'h01;
      case (dir)
         3'd0: step = 8'h01;   // +x
         3'd1: step = 8'h11;   // +x+y
         3'd2: step = 8'h10;   // +y
         3'd3: step = 8'h0F;   // -x+y
         3'd4: step = 8'hFF;   // -x
         3'd5: step = 8'hEF;   // -x-y
         3'd6: step = 8'hF0;   // -y
         3'd7: step = 8'hF1;   // +x-y
         default: step = 8'h01;
      endcase
      next = cood + step;
   end

endmodule

// File: rtl/othello_flip_scan.sv
// Move validation and flip engine: scans eight directions from the placed
// square through the board RAM, then writes the stone and every flanked stone.
module othello_flip_scan
   import othello_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] cood,
   input  logic [1:0] player,
   output logic       rd_en,
   output logic [7:0] rd_addr,
   input  logic [1:0] rd_data,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [1:0] wr_data,
   output logic       busy,
   output logic       done,
   output logic       legal,
   output logic [7:0] flip_mask,
   output logic [4:0] flip_count
);

   state_t     state, state_nx;
   logic [7:0] cood_r;
   logic [7:0] pos;
   logic [1:0] player_r;
   dir_t       dir;
   logic [2:0] run;
   logic [2:0] cnt;
   logic [2:0] len [8];

   logic [7:0] nxt;
   logic       nxt_off;
   logic [1:0] opp;
   logic       is_opp;
   logic       hit;
   logic [7:0] mask_upd;
   logic       walk_last;
   logic [3:0] first_dir;
   logic [3:0] later_dir;

   // {found, index} of the lowest set bit of m at or above lo
   function automatic logic [3:0] first_from(input logic [7:0] m, input logic [3:0] lo);
      logic [3:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (i >= int'(lo))) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   nextcood u_step (
      .cood (pos),
      .dir  (dir),
      .next (nxt)
   );

   always_comb begin
      opp       = (player_r == BLACK) ? WHITE : BLACK;
      nxt_off   = offboard(nxt);
      is_opp    = (rd_data == opp);
      hit       = (rd_data == player_r) && (run != 3'd0);
      mask_upd  = flip_mask;
      if (state == DIR_EV && hit) mask_upd = flip_mask | (8'b1 << dir);
      walk_last = ({1'b0, cnt} + 4'd1) == {1'b0, len[dir]};
      first_dir = first_from(flip_mask, 4'd0);
      later_dir = first_from(flip_mask, {1'b0, dir} + 4'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (start) state_nx = SELF_RD;
         SELF_RD:   state_nx = SELF_EV;
         SELF_EV:   state_nx = (rd_data != EMPTY) ? DONE : DIR_ISSUE;
         DIR_ISSUE: begin
            if (!nxt_off)           state_nx = DIR_EV;
            else if (dir == 3'd7)   state_nx = (|flip_mask) ? FLIP_SELF : DONE;
         end
         DIR_EV: begin
            if (is_opp)             state_nx = DIR_ISSUE;
            else if (dir == 3'd7)   state_nx = (|mask_upd) ? FLIP_SELF : DONE;
            else                    state_nx = DIR_ISSUE;
         end
         FLIP_SELF: state_nx = FLIP_WALK;
         FLIP_WALK: if (walk_last && !later_dir[3]) state_nx = DONE;
         DONE:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb begin
      rd_en   = 1'b0;
      rd_addr = 8'h00;
      wr_en   = 1'b0;
      wr_addr = 8'h00;
      busy    = (state != IDLE) && (state != DONE);
      done    = (state == DONE);
      case (state)
         SELF_RD: begin
            rd_en   = 1'b1;
            rd_addr = cood_r;
         end
         DIR_ISSUE: begin
            rd_en   = !nxt_off;
            rd_addr = nxt_off ? 8'h00 : nxt;
         end
         FLIP_SELF: begin
            wr_en   = 1'b1;
            wr_addr = cood_r;
         end
         FLIP_WALK: begin
            wr_en   = 1'b1;
            wr_addr = nxt;
         end
         default: ;
      endcase
   end

   assign wr_data = player_r;

   // Result registers: cleared on an accepted start, held after done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         player_r   <= 2'b00;
         legal      <= 1'b0;
         flip_mask  <= 8'h00;
         flip_count <= 5'd0;
      end else begin
         if (state == IDLE && start) begin
            player_r   <= player;
            legal      <= 1'b0;
            flip_mask  <= 8'h00;
            flip_count <= 5'd0;
         end
         if (state == DIR_EV && hit) begin
            flip_mask  <= mask_upd;
            flip_count <= flip_count + 5'(run);
         end
         if (state != DONE && state_nx == DONE) legal <= |mask_upd;
      end
   end

   // Walk datapath; only meaningful while the FSM is out of IDLE
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (start) begin
               cood_r <= cood;
               pos    <= cood;
               dir    <= 3'd0;
               run    <= 3'd0;
            end
         end
         SELF_EV: begin
            pos <= cood_r;
            dir <= 3'd0;
            run <= 3'd0;
         end
         DIR_ISSUE: begin
            if (nxt_off) begin
               pos <= cood_r;
               dir <= dir + 3'd1;
               run <= 3'd0;
            end else begin
               pos <= nxt;
            end
         end
         DIR_EV: begin
            if (is_opp) begin
               run <= run + 3'd1;
            end else begin
               if (hit) len[dir] <= run;
               pos <= cood_r;
               dir <= dir + 3'd1;
               run <= 3'd0;
            end
         end
         FLIP_SELF: begin
            pos <= cood_r;
            dir <= first_dir[2:0];
            cnt <= 3'd0;
         end
         FLIP_WALK: begin
            if (walk_last) begin
               pos <= cood_r;
               dir <= later_dir[2:0];
               cnt <= 3'd0;
            end else begin
               pos <= nxt;
               cnt <= cnt + 3'd1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_othello_flip_scan.sv
// Bench for othello_flip_scan: fixed boards from a vector table, a few
// hand-built sequences and random boards, all against a geometric board model.
module tb_othello_flip_scan;
   import othello_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] cood;
   logic [1:0] player;
   logic       rd_en;
   logic [7:0] rd_addr;
   logic [1:0] rd_data = 2'b00;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [1:0] wr_data;
   logic       busy;
   logic       done;
   logic       legal;
   logic [7:0] flip_mask;
   logic [4:0] flip_count;

   othello_flip_scan dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cood       (cood),
      .player     (player),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .legal      (legal),
      .flip_mask  (flip_mask),
      .flip_count (flip_count)
   );

   always #5 clk = ~clk;

   // board RAM: read-only stimulus, data one cycle after rd_en
   logic [1:0] mem [256];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   logic [7:0] rdq [$];
   logic [7:0] wrq [$];
   logic [1:0] wdq [$];
   int         both_cnt = 0;
   always @(negedge clk) begin
      if (rd_en) rdq.push_back(rd_addr);
      if (wr_en) begin
         wrq.push_back(wr_addr);
         wdq.push_back(wr_data);
      end
      if (rd_en && wr_en) both_cnt++;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // reference model: plain board geometry
   logic [7:0] m_rd [$];
   logic [7:0] m_wr [$];
   logic       m_legal;
   logic [7:0] m_mask;
   int         m_count;
   int         m_lat;

   task automatic model(input logic [7:0] c, input logic [1:0] p);
      int DX[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
      int DY[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
      int x, y, cx, cy, run, s;
      int lenv[8];
      logic [1:0] opp, v;
      logic [7:0] a;
      m_rd.delete();
      m_wr.delete();
      m_mask  = 8'h00;
      m_count = 0;
      m_legal = 1'b0;
      x   = int'(c[3:0]);
      y   = int'(c[7:4]);
      opp = (p == BLACK) ? WHITE : BLACK;
      m_rd.push_back(c);
      if (mem[c] != EMPTY) begin
         m_lat = 3;
         return;
      end
      s = 0;
      for (int d = 0; d < 8; d++) begin
         run     = 0;
         lenv[d] = 0;
         for (int k = 1; k <= 8; k++) begin
            cx = x + DX[d] * k;
            cy = y + DY[d] * k;
            if (cx < 0 || cx > 7 || cy < 0 || cy > 7) begin
               s += 1;
               break;
            end
            s += 2;
            a = 8'(cy * 16 + cx);
            m_rd.push_back(a);
            v = mem[a];
            if (v == opp) run++;
            else begin
               if (v == p && run > 0) begin
                  m_mask[d] = 1'b1;
                  lenv[d]   = run;
               end
               break;
            end
         end
      end
      m_legal = (m_mask != 8'h00);
      if (m_legal) begin
         m_wr.push_back(c);
         for (int d = 0; d < 8; d++) begin
            for (int k = 1; k <= lenv[d]; k++) m_wr.push_back(8'((y + DY[d] * k) * 16 + (x + DX[d] * k)));
            m_count += lenv[d];
         end
      end
      m_lat = 3 + s + (m_legal ? 1 + m_count : 0);
   endtask

   task automatic clear_board();
      for (int i = 0; i < 256; i++) mem[i] = EMPTY;
   endtask

   task automatic load_board(input int id);
      clear_board();
      case (id)
         0: begin
            mem[8'h33] = WHITE; mem[8'h44] = WHITE;
            mem[8'h34] = BLACK; mem[8'h43] = BLACK;
         end
         1: for (int i = 1; i < 8; i++) mem[i] = WHITE;
         2: begin
            mem[8'h11] = WHITE; mem[8'h22] = WHITE; mem[8'h33] = BLACK;
         end
         3: begin
            mem[8'h01] = WHITE; mem[8'h02] = BLACK;
            mem[8'h10] = WHITE; mem[8'h20] = WHITE; mem[8'h30] = BLACK;
         end
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [7:0] c, input logic [1:0] p, input bit inject,
                         output int lat, output logic o_legal, output logic [7:0] o_mask,
                         output logic [4:0] o_count);
      int  rb, wb, bb, n, busy_bad, errs;
      bit  got;
      model(c, p);
      rb = rdq.size();
      wb = wrq.size();
      bb = both_cnt;
      @(negedge clk);
      start  = 1'b1;
      cood   = c;
      player = p;
      n = 0;
      busy_bad = 0;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         n++;
         start  = 1'b0;
         cood   = 8'($urandom);
         player = p ^ 2'b11;
         if (inject && n == 4) begin
            start  = 1'b1;
            cood   = 8'h33;
            player = WHITE;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
         if (!busy) busy_bad++;
      end
      start = 1'b0;
      if (!got) chk("done_timeout", 0, 1);
      lat     = n;
      o_legal = legal;
      o_mask  = flip_mask;
      o_count = flip_count;
      chk("latency", n, m_lat);
      chk("busy_during_op", busy_bad, 0);
      chk("busy_at_done", busy, 0);
      chk("legal_model", legal, m_legal);
      chk("mask_model", flip_mask, m_mask);
      chk("count_model", flip_count, m_count);
      chk("rd_count", rdq.size() - rb, m_rd.size());
      errs = 0;
      for (int i = 0; i < m_rd.size(); i++)
         if (rb + i < rdq.size() && rdq[rb + i] != m_rd[i]) errs++;
      chk("rd_addr_seq", errs, 0);
      chk("wr_count", wrq.size() - wb, m_wr.size());
      errs = 0;
      for (int i = 0; i < m_wr.size(); i++) begin
         if (wb + i < wrq.size() && wrq[wb + i] != m_wr[i]) errs++;
         if (wb + i < wdq.size() && wdq[wb + i] != p) errs++;
      end
      chk("wr_addr_data_seq", errs, 0);
      chk("rd_wr_overlap", both_cnt - bb, 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("legal_held", legal, m_legal);
   endtask

   typedef struct {
      int         board;
      logic [7:0] c;
      logic [1:0] p;
      logic       el;
      logic [7:0] em;
      logic [4:0] ec;
      int         lat;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int         lat, nw, late;
      bit         fired;
      logic       ol;
      logic [7:0] om;
      logic [4:0] oc;
      logic [7:0] rc;

      vecs[0] = '{0, 8'h32, BLACK, 1'b1, 8'h01, 5'd1, 23};
      vecs[1] = '{0, 8'h33, BLACK, 1'b0, 8'h00, 5'd0, 3};
      vecs[2] = '{1, 8'h00, BLACK, 1'b0, 8'h00, 5'd0, 27};
      vecs[3] = '{2, 8'h00, BLACK, 1'b1, 8'h02, 5'd2, 21};
      vecs[4] = '{3, 8'h00, BLACK, 1'b1, 8'h05, 5'd3, 24};
      vecs[5] = '{0, 8'h35, WHITE, 1'b1, 8'h10, 5'd1, 23};

      rst_n  = 1'b0;
      start  = 1'b0;
      cood   = 8'h00;
      player = 2'b00;
      clear_board();
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_legal", legal, 0);
      chk("reset_mask", flip_mask, 0);
      chk("reset_count", flip_count, 0);
      chk("reset_rd_en", rd_en, 0);
      chk("reset_wr_en", wr_en, 0);
      chk("reset_wr_data", wr_data, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         load_board(vecs[v].board);
         run_op(vecs[v].c, vecs[v].p, 1'b0, lat, ol, om, oc);
         chk("tbl_legal", ol, vecs[v].el);
         chk("tbl_mask", om, vecs[v].em);
         chk("tbl_count", oc, vecs[v].ec);
         chk("tbl_latency", lat, vecs[v].lat);
      end

      // start pulse while busy must not disturb the running move
      load_board(0);
      run_op(8'h32, BLACK, 1'b1, lat, ol, om, oc);
      chk("busy_start_mask", om, 8'h01);
      chk("busy_start_count", oc, 1);
      @(negedge clk);
      chk("busy_start_no_restart", busy, 0);

      // reset asserted while the second flip write is on the bus
      load_board(2);
      @(negedge clk);
      start  = 1'b1;
      cood   = 8'h00;
      player = BLACK;
      nw = 0;
      fired = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (wr_en) nw++;
         if (nw == 2) begin
            fired = 1'b1;
            break;
         end
      end
      chk("reset_reached_2nd_write", fired, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_strobes", {wr_en, rd_en, busy, done}, 0);
      chk("async_rst_results", {legal, flip_mask, flip_count}, 0);
      late = 0;
      repeat (4) begin
         @(negedge clk);
         late += int'(wr_en) + int'(rd_en);
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         late += int'(wr_en) + int'(rd_en);
      end
      chk("no_access_after_reset", late, 0);
      run_op(8'h00, BLACK, 1'b0, lat, ol, om, oc);
      chk("post_reset_legal", ol, 1);
      chk("post_reset_mask", om, 8'h02);
      chk("post_reset_count", oc, 2);

      // random boards against the model
      for (int t = 0; t < 30; t++) begin
         clear_board();
         for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
               mem[8'(y * 16 + x)] = 2'($urandom_range(0, 2));
         rc = {1'b0, 3'($urandom_range(0, 7)), 1'b0, 3'($urandom_range(0, 7))};
         if ($urandom_range(0, 3) != 0) mem[rc] = EMPTY;
         run_op(rc, ($urandom_range(0, 1) != 0) ? BLACK : WHITE, 1'b0, lat, ol, om, oc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/othello_flip_scan.md
# othello_flip_scan

Move-validation and flip engine for the FPGA Othello board. Given a placement coordinate and the player's colour, it walks all eight directions from that square. It uses the existing `nextcood` step module to generate each next coordinate, reads the board cell by cell, and decides which directions flank opponent stones. If the move is legal, it then issues board writes that place the stone and flip every flanked opponent stone. It sits between the move-input controller (upstream) and the board RAM (read and write ports).

## Interface
Parameters:
- none; all encodings come from `othello_pkg`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `cood`  in  8  placement coordinate, {y[3:0], x[3:0]}; x and y are 0..7.
- `player`  in  2  colour being placed: BLACK=2'b01 or WHITE=2'b10.
- `rd_en`  out  1  board read strobe.
- `rd_addr`  out  8  board read coordinate.
- `rd_data`  in  2  cell contents; valid exactly one cycle after `rd_en`.
- `wr_en`  out  1  board write strobe.
- `wr_addr`  out  8  board write coordinate.
- `wr_data`  out  2  value to write; always equals the latched `player`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the operation completes.
- `legal`  out  1  valid with `done` and held until the next start; 1 if at least one direction flanks.
- `flip_mask`  out  8  bit d = 1 if direction d flanks; held like `legal`.
- `flip_count`  out  5  total number of opponent stones flipped; held like `legal`.

## Operation
- Direction encoding matches `nextcood`: 0 +x, 1 +x+y, 2 +y, 3 −x+y, 4 −x, 5 −x−y, 6 −y, 7 +x−y.
- Off-board test: a coordinate is off-board when bit 3 or bit 7 is set. This also catches x-borrow corruption of y at x=0, because x then becomes F.
- States: IDLE → SELF_RD → SELF_EV → (DIR_ISSUE ↔ DIR_EV) × 8 → FLIP_SELF → FLIP_WALK → DONE → IDLE.
- Accepting `start` latches `cood` and `player`.
- SELF: read `cood`. If the cell is non-empty, go directly to DONE with `legal`=0 and `flip_mask`=0.
- Direction scan runs d = 0..7 in ascending order. For each direction:
  - Step the position with `nextcood`.
  - If the new position is off-board, fail d without issuing a read.
  - Otherwise DIR_ISSUE drives the read and DIR_EV evaluates `rd_data`.
- Evaluation at distance k:
  - opponent → continue and increment the run counter (3 bits, max 6).
  - own colour with k ≥ 2 → d succeeds; record its run length.
  - own colour with k = 1 → d fails.
  - empty or off-board → d fails.
- A per-direction run-length table (8 × 3 bits) is retained for the flip phase.
- If no direction succeeds after d=7, go to DONE with `legal`=0 and no writes.
- Flip phase:
  - FLIP_SELF writes `cood`.
  - FLIP_WALK then handles each successful direction in ascending order: it restarts from `cood` and writes the next `len[d]` cells, one write per cycle.
- `flip_count` = sum of the recorded run lengths.
- The board is never written during scanning.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset is asynchronous and takes effect mid-operation: outputs drop immediately and no further reads or writes are issued.
- `start` in cycle T → `busy`=1 at T+1 and `rd_en` for `cood` at T+1.
- Each examined on-board cell costs 2 cycles: issue, then evaluate. An off-board step costs 1 cycle.
- Writes are back-to-back: 1 + `flip_count` consecutive `wr_en` cycles.
- `done` is asserted one cycle after the last write or the last evaluation. `busy` falls in the same cycle as `done`.
- `start` while `busy` is ignored, with no side effects.
- `rd_en` and `wr_en` are never high in the same cycle.

## Structure
- `othello_pkg` holds:
  - cell constants EMPTY/BLACK/WHITE;
  - the 3-bit direction type;
  - the FSM state enum;
  - an `offboard(coord)` function.
- One instance of the existing `nextcood` module, fed by the current position register and the direction counter. No other sub-modules.

## Test plan
- Standard opening (0x33=W, 0x44=W, 0x34=B, 0x43=B), BLACK at 0x32 → `legal`=1, `flip_mask`=8'h01, `flip_count`=1, writes 0x32 then 0x33 with 2'b01.
- Same board, BLACK at 0x33 (occupied) → `done` 3 cycles after `start`, `legal`=0, no `wr_en`.
- Row y=0 with x=1..7 all WHITE, BLACK at 0x00 → direction 0 fails at off-board 0x08, `legal`=0, zero writes. Directions 3–7 never assert `rd_en`.
- BLACK at 0x00, WHITE at 0x11 and 0x22, BLACK at 0x33 → `flip_mask`=8'h02, `flip_count`=2, writes 0x00, 0x11, 0x22.
- Two flanking directions (d=0 length 1, d=2 length 2) → writes in the order `cood`, d0 cells, d2 cells; `flip_count`=3.
- `rst_n` pulled low during the second flip write → outputs drop to 0 immediately, no later writes; a fresh `start` after release behaves normally.
